// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result path: unload FSM states, frame length
// and the {re, im} packing of complex bins.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Imaginary part sits in the low half of a packed bin, real part above it.
  localparam int unsigned IM_LSB = 0;

  function automatic int unsigned re_lsb(input int unsigned w);
    return w;
  endfunction

  // Bins emitted per frame: half the spectrum for real-input FFTs.
  function automatic int unsigned bins_per_frame(input int unsigned n2, input bit half);
    return half ? (32'd1 << (n2 - 1)) : (32'd1 << n2);
  endfunction

endpackage

// File: rtl/fft_unload_mag_sq.sv
// Combinational squared magnitude of a packed signed {re, im} bin.
// The sum is exact in 2*width unsigned bits, so no rounding or saturation is needed.
module mag_sq
  import fft_pkg::*;
#(
  parameter int unsigned width = 16
) (
  input  logic [2*width-1:0] cplx_i,
  output logic [2*width-1:0] mag_o
);

  localparam int unsigned RE_LSB = re_lsb(width);

  logic signed [width-1:0]   re;
  logic signed [width-1:0]   im;
  logic signed [2*width-1:0] re_x;
  logic signed [2*width-1:0] im_x;
  logic signed [2*width-1:0] re_sq;
  logic signed [2*width-1:0] im_sq;

  assign re    = cplx_i[RE_LSB +: width];
  assign im    = cplx_i[IM_LSB +: width];
  assign re_x  = {{width{re[width-1]}}, re};
  assign im_x  = {{width{im[width-1]}}, im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  // Each square is at most 2^(2*width-2), so the unsigned sum cannot wrap.
  assign mag_o = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fft_unload.sv
// Walks the FFT result RAM after done rises and streams |bin|^2 downstream
// over a valid/ready handshake with full backpressure.
module fft_unload
  import fft_pkg::*;
#(
  parameter int unsigned width = 16,
  parameter int unsigned N_2   = 5,
  parameter bit          HALF  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               done,
  output logic [N_2-1:0]     adr,
  input  logic [2*width-1:0] rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*width-1:0] out_mag,
  output logic [N_2-1:0]     out_bin,
  output logic               out_last,
  output logic               busy,
  output logic               unloaded
);

  localparam int unsigned    M        = bins_per_frame(N_2, HALF);
  localparam logic [N_2-1:0] LAST_BIN = N_2'(M - 1);

  state_t             state_q, state_d;
  logic [N_2-1:0]     cnt_q, cnt_d;
  logic               done_q;
  logic               valid_q, valid_d;
  logic [2*width-1:0] mag_q, mag_d;
  logic [N_2-1:0]     bin_q, bin_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               unloaded_q, unloaded_d;
  logic [2*width-1:0] mag_w;

  mag_sq #(.width(width)) u_mag_sq (
    .cplx_i (rd),
    .mag_o  (mag_w)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    mag_d      = mag_q;
    bin_d      = bin_q;
    last_d     = last_q;
    unloaded_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (done && !done_q) state_d = RUN;
      end
      RUN: begin
        if (!done) begin
          state_d = IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (!valid_q || out_ready) begin
          valid_d = 1'b1;
          mag_d   = mag_w;
          bin_d   = cnt_q;
          last_d  = (cnt_q == LAST_BIN);
          cnt_d   = cnt_q + N_2'(1);
          if (cnt_q == LAST_BIN) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (!done) begin
          state_d = IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (valid_q && out_ready) begin
          valid_d    = 1'b0;
          unloaded_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Stay here until done drops so the same done level cannot retrigger.
        if (!done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b1;
      valid_q    <= 1'b0;
      mag_q      <= '0;
      bin_q      <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      unloaded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done;
      valid_q    <= valid_d;
      mag_q      <= mag_d;
      bin_q      <= bin_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      unloaded_q <= unloaded_d;
    end
  end

  assign adr       = cnt_q;
  assign out_valid = valid_q;
  assign out_mag   = mag_q;
  assign out_bin   = bin_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign unloaded  = unloaded_q;

endmodule

// File: tb/tb_fft_unload.sv
// Scoreboard bench for fft_unload: stimulus queues expected beats, a negedge
// monitor pops and compares every accepted beat and checks stall stability.
module tb_fft_unload;

  localparam int W  = 16;
  localparam int N2 = 5;
  localparam int M  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            done;
  logic [N2-1:0]   adr;
  logic [2*W-1:0]  rd;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_mag;
  logic [N2-1:0]   out_bin;
  logic            out_last;
  logic            busy;
  logic            unloaded;

  logic [2*W-1:0]  ram [0:31];

  typedef struct packed {
    logic [2*W-1:0] mag;
    logic [N2-1:0]  bin;
    logic           last;
  } beat_t;

  beat_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  assign rd = ram[adr];

  fft_unload #(.width(W), .N_2(N2), .HALF(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .adr       (adr),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_bin   (out_bin),
    .out_last  (out_last),
    .busy      (busy),
    .unloaded  (unloaded)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    logic signed [W-1:0] re, im;
    for (int k = 0; k < 32; k++) begin
      re = W'(k);
      im = -W'(k);
      ram[k] = {re, im};
    end
  endtask

  // Expected squared magnitude for the ramp pattern {k, -k} is 2*k*k.
  task automatic push_ramp(input int nbins);
    beat_t b;
    for (int k = 0; k < nbins; k++) begin
      b.mag  = 32'(2 * k * k);
      b.bin  = N2'(k);
      b.last = (k == M - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int n);
    if (mode == 1) return (n % 2) == 0;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_adr"},       64'(adr),       64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_mag"},   64'(out_mag),   64'd0);
    chk({tag, "_out_bin"},   64'(out_bin),   64'd0);
    chk({tag, "_out_last"},  64'(out_last),  64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_unloaded"},  64'(unloaded),  64'd0);
  endtask

  // Runs one frame from a fresh done rising edge until unloaded is seen.
  task automatic run_frame(input string tag, input int mode);
    int cyc;
    int stalls;
    done      = 1'b0;
    out_ready = 1'b1;
    tick();
    done      = 1'b1;
    out_ready = ready_pat(mode, 0);
    cyc       = 0;
    stalls    = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      cyc++;
      if (unloaded) break;
      out_ready = ready_pat(mode, cyc);
      if (out_valid && !out_ready) stalls++;
    end
    out_ready = 1'b1;
    chk({tag, "_frame_cycles"}, 64'(cyc), 64'(18 + stalls));
    tick();
    chk({tag, "_unloaded_width"}, 64'(unloaded),  64'd0);
    chk({tag, "_valid_after"},    64'(out_valid), 64'd0);
    chk({tag, "_busy_after"},     64'(busy),      64'd0);
    chk({tag, "_sb_empty"},       64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare accepted beats, and hold values stable while stalled.
  logic           stall_seen = 1'b0;
  logic [2*W-1:0] stall_mag;
  logic [N2-1:0]  stall_bin;
  logic           stall_last;

  always @(negedge clk) begin
    beat_t b;
    if (reset) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && out_valid) begin
        chk("stall_mag",  64'(out_mag),  64'(stall_mag));
        chk("stall_bin",  64'(out_bin),  64'(stall_bin));
        chk("stall_last", 64'(out_last), 64'(stall_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_bin", 64'(out_bin), 64'hFFFF);
        end else begin
          b = exp_q.pop_front();
          chk("beat_mag",  64'(out_mag),  64'(b.mag));
          chk("beat_bin",  64'(out_bin),  64'(b.bin));
          chk("beat_last", 64'(out_last), 64'(b.last));
        end
      end
      stall_seen = out_valid && !out_ready;
      stall_mag  = out_mag;
      stall_bin  = out_bin;
      stall_last = out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    reset     = 1'b1;
    done      = 1'b1;
    out_ready = 1'b1;
    fill_ramp();

    // Reset with done already high: outputs zero, no frame afterwards.
    tick(); tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("no_frame_after_reset_busy",  64'(busy),      64'd0);
    chk("no_frame_after_reset_valid", 64'(out_valid), 64'd0);

    // Ramp frame, ready held high, then confirm HOLD ignores the same done.
    push_ramp(M);
    run_frame("ramp", 0);
    for (int i = 0; i < 4; i++) tick();
    chk("hold_busy",  64'(busy),      64'd0);
    chk("hold_valid", 64'(out_valid), 64'd0);

    // Backpressure: alternating, then random ready.
    push_ramp(M);
    run_frame("toggle", 1);
    push_ramp(M);
    run_frame("random", 2);

    // Extreme component values.
    for (int k = 0; k < 32; k++) ram[k] = '0;
    ram[0] = {16'sh8000, 16'sh8000};
    ram[1] = {16'sh7FFF, 16'sh0000};
    ram[2] = {16'shFFFF, 16'sh0001};
    for (int k = 0; k < M; k++) begin
      b.mag  = (k == 0) ? 32'h8000_0000 : (k == 1) ? 32'h3FFF_0001 : (k == 2) ? 32'd2 : 32'd0;
      b.bin  = N2'(k);
      b.last = (k == M - 1);
      exp_q.push_back(b);
    end
    run_frame("extreme", 0);

    // Abort after bin 5 is accepted, then restart from bin 0.
    fill_ramp();
    push_ramp(6);
    done      = 1'b0;
    out_ready = 1'b1;
    tick();
    done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid && out_bin == N2'(5)) break;
    end
    tick();
    done      = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("abort_valid",    64'(out_valid), 64'd0);
    chk("abort_busy",     64'(busy),      64'd0);
    chk("abort_unloaded", 64'(unloaded),  64'd0);
    chk("abort_sb_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_unloaded", 64'(unloaded), 64'd0);
    end
    push_ramp(M);
    run_frame("restart", 0);

    // Reset while stalled in DRAIN.
    push_ramp(M - 1);
    done      = 1'b0;
    out_ready = 1'b1;
    tick();
    done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid && out_last) break;
    end
    out_ready = 1'b0;
    tick();
    chk("drain_busy",  64'(busy),      64'd1);
    chk("drain_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("drain_reset");
    reset = 1'b0;
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("post_reset_idle_busy", 64'(busy), 64'd0);
    push_ramp(M);
    run_frame("post_reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
